// File: rtl/hex_display_scanner.sv
// Time-multiplexed scan controller driving one shared hex 7-seg decoder across NUM_DIGITS digits.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits (digit 0 is always shown).
module hex_display_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int TICKS_PER_DIGIT  = 50000,
    parameter int BLANK_TICKS      = 1000,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    output logic [3:0]              o_nibble,
    output logic                    o_blank,
    output logic [NUM_DIGITS-1:0]   o_digit_en,
    output logic                    o_pending,
    output logic                    o_frame_start
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(TICKS_PER_DIGIT);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] SHOW_CNT = CW'(BLANK_TICKS);
    localparam logic [NUM_DIGITS-1:0] EN_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;
    localparam state_t SLOT_ENTRY = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic                    running, running_n;
    logic [4*NUM_DIGITS-1:0] disp, disp_n;
    logic [4*NUM_DIGITS-1:0] pend_val, pend_val_n;
    logic                    pending_n;
    logic                    boundary;
    logic                    suppress;
    logic                    shown;
    logic [NUM_DIGITS-1:0]   sel;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] v, input logic [IW-1:0] k);
        return (k != '0) && ((v >> (4 * k)) == '0);
    endfunction
`endif

    // Next-state: outputs are registered from these so nibble, enable and blank move together.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        running_n  = running;
        disp_n     = disp;
        pend_val_n = pend_val;
        pending_n  = o_pending;
        boundary   = 1'b0;

        if (!i_enable) begin
            state_n   = ST_BLANK;
            idx_n     = '0;
            cnt_n     = '0;
            running_n = 1'b0;
            if (i_load) begin
                disp_n    = i_value;
                pending_n = 1'b0;
            end
        end else begin
            if (!running) begin
                // First enabled cycle after reset or a dark period starts a fresh frame.
                running_n = 1'b1;
                idx_n     = '0;
                cnt_n     = '0;
                state_n   = SLOT_ENTRY;
                boundary  = 1'b1;
            end else if (cnt == LAST_CNT) begin
                cnt_n    = '0;
                state_n  = SLOT_ENTRY;
                idx_n    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                boundary = (idx == LAST_IDX);
            end else begin
                cnt_n = cnt + 1'b1;
                if (cnt_n == SHOW_CNT) state_n = ST_SHOW;
            end

            if (boundary) begin
                if (i_load)         disp_n = i_value;
                else if (o_pending) disp_n = pend_val;
                pending_n = 1'b0;
            end else if (i_load) begin
                pend_val_n = i_value;
                pending_n  = 1'b1;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        suppress = lead_zero(disp_n, idx_n);
`else
        suppress = 1'b0;
`endif
        shown       = (state_n == ST_SHOW) && !suppress;
        sel         = '0;
        sel[idx_n]  = shown;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_BLANK;
            idx           <= '0;
            cnt           <= '0;
            running       <= 1'b0;
            disp          <= '0;
            pend_val      <= '0;
            o_pending     <= 1'b0;
            o_nibble      <= 4'h0;
            o_blank       <= 1'b1;
            o_digit_en    <= EN_OFF;
            o_frame_start <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            running       <= running_n;
            disp          <= disp_n;
            pend_val      <= pend_val_n;
            o_pending     <= pending_n;
            o_nibble      <= disp_n[4*idx_n +: 4];
            o_blank       <= !shown;
            o_digit_en    <= sel ^ EN_OFF;
            o_frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: expectations queued per cycle, a negedge monitor compares.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame_start;

    int cyc = 0;
    int compared = 0;
    int failed = 0;

    typedef struct {
        int         c;
        logic [3:0] en;
        logic [3:0] nib;
        logic       chk_nib;
        logic       bl;
        logic       fs;
        logic       pd;
        string      name;
    } exp_t;
    exp_t q[$];

    hex_display_scanner #(
        .NUM_DIGITS(4), .TICKS_PER_DIGIT(8), .BLANK_TICKS(2), .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_load(load), .i_value(value),
        .o_nibble(nibble), .o_blank(blank), .o_digit_en(digit_en),
        .o_pending(pending), .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] en, input logic [3:0] nib, input logic chk,
                        input logic bl, input logic fs, input logic pd, input string name);
        exp_t e;
        e.c = c; e.en = en; e.nib = nib; e.chk_nib = chk; e.bl = bl; e.fs = fs; e.pd = pd; e.name = name;
        q.push_back(e);
    endtask

    task automatic show(input int c, input logic [3:0] en, input logic [3:0] nib, input logic pd, input string name);
        push(c, en, nib, 1'b1, 1'b0, 1'b0, pd, name);
    endtask

    task automatic gap(input int c, input logic [3:0] nib, input logic fs, input logic pd, input string name);
        push(c, 4'b1111, nib, 1'b1, 1'b1, fs, pd, name);
    endtask

    task automatic dark(input int c, input string name);
        push(c, 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, name);
    endtask

    // A leading-zero digit is dark when suppression is built in.
    task automatic show_lz(input int c, input logic [3:0] en, input logic [3:0] nib, input string name);
`ifdef LEADING_ZERO_BLANK_EN
        push(c, 4'b1111, nib, 1'b1, 1'b1, 1'b0, 1'b0, name);
`else
        show(c, en, nib, 1'b0, name);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            compared++;
            if (!$onehot0(~digit_en)) begin
                failed++;
                $display("FAIL onehot cyc=%0d digit_en=%b required at most one active", cyc, digit_en);
            end
        end
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            compared++;
            if (e.c < cyc) begin
                failed++;
                $display("FAIL %s missed cyc=%0d (now %0d)", e.name, e.c, cyc);
            end else if (digit_en !== e.en || blank !== e.bl || frame_start !== e.fs ||
                         pending !== e.pd || (e.chk_nib && nibble !== e.nib)) begin
                failed++;
                $display("FAIL %s cyc=%0d got en=%b nib=%h blank=%b fs=%b pend=%b required en=%b nib=%h blank=%b fs=%b pend=%b",
                         e.name, cyc, digit_en, nibble, blank, frame_start, pending,
                         e.en, e.nib, e.bl, e.fs, e.pd);
            end
        end
    end

    initial begin
        int b, c, d, e;
        logic [3:0] nibs [4];
        logic [3:0] ens  [4];
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        gap(cyc, 4'h0, 1'b0, 1'b0, "reset");

        // Load while dark goes straight to the display register.
        rst_n = 1'b1; load = 1'b1; value = 16'hA3C5;
        tick();
        dark(cyc, "idle_load");
        load = 1'b0; enable = 1'b1;
        b = cyc + 1;
        c = b + 150;
        d = c + 19;
        e = d + 32;

        nibs = '{4'h5, 4'hC, 4'h3, 4'hA};
        ens  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 4; i++) begin
            gap(b + 8*i,     nibs[i], (i == 0), 1'b0, "f1_blank0");
            gap(b + 8*i + 1, nibs[i], 1'b0,     1'b0, "f1_blank1");
            show(b + 8*i + 2, ens[i], nibs[i],  1'b0, "f1_show_first");
            show(b + 8*i + 7, ens[i], nibs[i],  1'b0, "f1_show_last");
        end
        gap(b + 32, 4'h5, 1'b1, 1'b0, "f2_start");
        show(b + 42, 4'b1101, 4'hC, 1'b1, "pend_old_d1");
        show(b + 58, 4'b0111, 4'hA, 1'b1, "pend_old_d3");
        gap(b + 64, 4'h2, 1'b1, 1'b0, "pend_xfer");
        show(b + 66, 4'b1110, 4'h2, 1'b0, "last_win_d0");
        show(b + 74, 4'b1101, 4'h2, 1'b0, "last_win_d1");
        show(b + 82, 4'b1011, 4'h2, 1'b0, "last_win_d2");
        show(b + 90, 4'b0111, 4'h2, 1'b0, "last_win_d3");
        gap(b + 96, 4'hF, 1'b1, 1'b0, "bnd_load");
        gap(b + 97, 4'hF, 1'b0, 1'b0, "bnd_nopend");
        show(b + 98, 4'b1110, 4'hF, 1'b0, "bnd_d0");
        show(b + 106, 4'b1101, 4'h0, 1'b0, "bnd_d1");
        show(b + 114, 4'b1011, 4'hF, 1'b0, "bnd_d2");
        show_lz(b + 122, 4'b0111, 4'h0, "bnd_d3");
        gap(b + 128, 4'hF, 1'b1, 1'b0, "f5_start");
        show(b + 147, 4'b1011, 4'hF, 1'b0, "pre_rst_d2");
        gap(b + 149, 4'h0, 1'b0, 1'b0, "mid_rst");
        gap(b + 150, 4'h0, 1'b1, 1'b0, "rst_restart");
        show(b + 152, 4'b1110, 4'h0, 1'b0, "rst_d0");
        show_lz(b + 162, 4'b1101, 4'h0, "rst_d1");
        dark(c + 14, "dis_a");
        dark(c + 16, "dis_b");
        dark(c + 18, "dis_c");
        gap(d, 4'h7, 1'b1, 1'b0, "reen_start");
        show(d + 2, 4'b1110, 4'h7, 1'b0, "reen_d0");
        show(d + 10, 4'b1101, 4'hB, 1'b0, "reen_d1");
        show_lz(d + 18, 4'b1011, 4'h0, "reen_d2");
        show_lz(d + 26, 4'b0111, 4'h0, "reen_d3");
        gap(e, 4'h0, 1'b1, 1'b0, "v70_start");
        show(e + 2, 4'b1110, 4'h0, 1'b0, "v70_d0");
        show(e + 10, 4'b1101, 4'h7, 1'b0, "v70_d1");
        show_lz(e + 18, 4'b1011, 4'h0, "v70_d2");
        show_lz(e + 26, 4'b0111, 4'h0, "v70_d3");
        gap(e + 32, 4'h0, 1'b1, 1'b0, "v70_next");

        wait_to(b + 40); load = 1'b1; value = 16'h1111;
        wait_to(b + 41); value = 16'h2222;
        wait_to(b + 42); load = 1'b0;
        wait_to(b + 95); load = 1'b1; value = 16'h0F0F;
        wait_to(b + 96); load = 1'b0;
        wait_to(b + 148); rst_n = 1'b0;
        wait_to(b + 149); rst_n = 1'b1;
        wait_to(c + 13); enable = 1'b0;
        wait_to(c + 14); load = 1'b1; value = 16'h00B7;
        wait_to(c + 15); load = 1'b0;
        wait_to(c + 18); enable = 1'b1;
        wait_to(d + 31); load = 1'b1; value = 16'h0070;
        wait_to(e); load = 1'b0;
        wait_to(e + 32);

        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            $display("FAIL timeout %0d expectations never reached", q.size());
            failed += q.size();
            compared += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
